// File: rtl/finish_wavefront_pkg.sv
// Shared types and helpers for the finish wavefront controller.
`default_nettype none

package finish_wavefront_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Anti-diagonal index of PE(r,c); tiled mode folds coordinates into one tile.
  function automatic int diag_idx(input int r, input int c, input logic tile_mode, input int tile);
    if (tile_mode) return (r % tile) + (c % tile);
    return r + c;
  endfunction

  function automatic int diag_width(input int size);
    return 2 * size - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/finish_wavefront_ctrl_diag_shift.sv
// Load/shift register carrying the active anti-diagonal token.
`default_nettype none

module diag_shift #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift,
  input  logic         load,
  output logic [W-1:0] q
);

  generate
    if (W == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (clr)   q <= '0;
        else if (shift) q <= load;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     q <= '0;
        else if (clr)   q <= '0;
        else if (shift) q <= {q[W-2:0], load};
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/finish_wavefront_ctrl.sv
// Per-PE finish wavefront generator for a SIZE x SIZE systolic array (whole or tiled).
// Optional build macro FINISH_STICKY_EN makes finish bits accumulate until the next start.
`default_nettype none

module finish_wavefront_ctrl
  import finish_wavefront_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int TILE = 4,
  parameter int KW   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   tile_mode,
  output logic                   busy,
  output logic [SIZE*SIZE-1:0]   finish,
  output logic                   done
);

  localparam int DIAG_W = diag_width(SIZE);
  localparam int CW     = KW + $clog2(2 * SIZE) + 1;
  localparam logic [CW-1:0] DMAX_WHOLE = CW'(2 * (SIZE - 1));
  localparam logic [CW-1:0] DMAX_TILE  = CW'(2 * (TILE - 1));

  state_t              state, state_nx;
  logic [CW-1:0]       count, count_inc, last_count;
  logic [KW-1:0]       k_len_q;
  logic                tile_q;
  logic [DIAG_W-1:0]   diag;
  logic                diag_clr, diag_shift_en, diag_load;
  logic                accept;
  logic [SIZE*SIZE-1:0] wave;

  assign accept     = (state == IDLE) && start;
  assign count_inc  = count + 1'b1;
  assign last_count = CW'(k_len_q) + (tile_q ? DMAX_TILE : DMAX_WHOLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    diag_clr      = 1'b0;
    diag_shift_en = 1'b0;
    diag_load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx      = RUN;
          diag_shift_en = 1'b1;
          diag_load     = (k_len == '0);
        end else begin
          diag_clr = 1'b1;
        end
      end
      RUN: begin
        // The last diagonal has just been shown; the done cycle carries no finish.
        if (count == last_count) begin
          state_nx = DONE;
          diag_clr = 1'b1;
        end else begin
          diag_shift_en = 1'b1;
          diag_load     = (count_inc == CW'(k_len_q));
        end
      end
      DONE: begin
        state_nx = IDLE;
        diag_clr = 1'b1;
      end
      default: begin
        state_nx = IDLE;
        diag_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      k_len_q <= '0;
      tile_q  <= 1'b0;
    end else if (accept) begin
      count   <= '0;
      k_len_q <= k_len;
      tile_q  <= tile_mode;
    end else if (state == RUN) begin
      count   <= count_inc;
    end
  end

  diag_shift #(.W(DIAG_W)) u_diag (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (diag_clr),
    .shift (diag_shift_en),
    .load  (diag_load),
    .q     (diag)
  );

  generate
    for (genvar r = 0; r < SIZE; r++) begin : g_row
      for (genvar c = 0; c < SIZE; c++) begin : g_col
        localparam int DW = diag_idx(r, c, 1'b0, TILE);
        localparam int DT = diag_idx(r, c, 1'b1, TILE);
        assign wave[r*SIZE+c] = tile_q ? diag[DT] : diag[DW];
      end
    end
  endgenerate

`ifdef FINISH_STICKY_EN
  logic [SIZE*SIZE-1:0] sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sticky <= '0;
    else if (accept) sticky <= '0;
    else             sticky <= sticky | wave;
  end

  assign finish = sticky | wave;
`else
  assign finish = wave;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_finish_wavefront_ctrl.sv
// Self-checking bench for finish_wavefront_ctrl (SIZE=8, TILE=4, KW=8).
`default_nettype none

module tb_finish_wavefront_ctrl;

  localparam int SIZE = 8;
  localparam int TILE = 4;
  localparam int KW   = 8;
  localparam int N    = SIZE * SIZE;
`ifdef FINISH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, start, tile_mode;
  logic [KW-1:0] k_len;
  logic          busy, done;
  logic [N-1:0]  finish;

  always #5 clk = ~clk;

  finish_wavefront_ctrl #(.SIZE(SIZE), .TILE(TILE), .KW(KW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .k_len     (k_len),
    .tile_mode (tile_mode),
    .busy      (busy),
    .finish    (finish),
    .done      (done)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] h_fin  [0:299];
  logic         h_busy [0:299];
  logic         h_done [0:299];

  typedef struct {
    int k;
    bit mode;
    int t;
    int probe;
    bit pval;
    int pop;
    bit edone;
    bit ebusy;
  } vec_t;

  vec_t vecs [14];

  function automatic int dmax_of(input bit mode);
    return mode ? 2 * (TILE - 1) : 2 * (SIZE - 1);
  endfunction

  // Expected finish vector t cycles after the accepting edge, straight from the wavefront rule.
  function automatic logic [N-1:0] model_fin(input int k, input bit mode, input int t);
    logic [N-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) begin
        int d;
        d = mode ? (r % TILE) + (c % TILE) : r + c;
        if (STICKY ? (t >= k + d) : (t == k + d)) v[r*SIZE+c] = 1'b1;
      end
    return v;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // DUT must be idle on entry; records n cycles starting with the cycle after the accepting edge.
  task automatic run_pass(input int k, input bit mode, input int n);
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); tile_mode = mode;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < n; t++) begin
      h_fin[t] = finish; h_busy[t] = busy; h_done[t] = done;
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_hist(input string tag, input int k, input bit mode, input int n);
    int last;
    last = k + dmax_of(mode) + 1;
    for (int t = 0; t < n; t++) begin
      check($sformatf("%s finish t=%0d", tag, t), h_fin[t], model_fin(k, mode, t));
      check_int($sformatf("%s busy t=%0d", tag, t), int'(h_busy[t]), (t <= last) ? 1 : 0);
      check_int($sformatf("%s done t=%0d", tag, t), int'(h_done[t]), (t == last) ? 1 : 0);
    end
  endtask

  initial begin
    int rises[$];
    int prev_busy, n, k, cyc_since, waited;
    bit mode;

    rst_n = 1'b0; start = 1'b0; k_len = '0; tile_mode = 1'b0;
    #1;
    check("reset finish", finish, '0);
    check_int("reset busy", int'(busy), 0);
    check_int("reset done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs[0]  = '{3, 1'b0, 3,  0,  1'b1, 1,                 1'b0, 1'b1};
    vecs[1]  = '{3, 1'b0, 5,  9,  1'b1, STICKY ? 6 : 3,    1'b0, 1'b1};
    vecs[2]  = '{3, 1'b0, 5,  16, 1'b1, STICKY ? 6 : 3,    1'b0, 1'b1};
    vecs[3]  = '{3, 1'b0, 17, 63, 1'b1, STICKY ? 64 : 1,   1'b0, 1'b1};
    vecs[4]  = '{3, 1'b0, 18, 63, STICKY, STICKY ? 64 : 0, 1'b1, 1'b1};
    vecs[5]  = '{3, 1'b0, 19, 63, STICKY, STICKY ? 64 : 0, 1'b0, 1'b0};
    vecs[6]  = '{2, 1'b1, 2,  0,  1'b1, 4,                 1'b0, 1'b1};
    vecs[7]  = '{2, 1'b1, 2,  36, 1'b1, 4,                 1'b0, 1'b1};
    vecs[8]  = '{2, 1'b1, 8,  27, 1'b1, STICKY ? 64 : 4,   1'b0, 1'b1};
    vecs[9]  = '{2, 1'b1, 8,  63, 1'b1, STICKY ? 64 : 4,   1'b0, 1'b1};
    vecs[10] = '{2, 1'b1, 9,  59, STICKY, STICKY ? 64 : 0, 1'b1, 1'b1};
    vecs[11] = '{0, 1'b0, 0,  0,  1'b1, 1,                 1'b0, 1'b1};
    vecs[12] = '{0, 1'b0, 14, 63, 1'b1, STICKY ? 64 : 1,   1'b0, 1'b1};
    vecs[13] = '{0, 1'b0, 15, 0,  STICKY, STICKY ? 64 : 0, 1'b1, 1'b1};

    for (int i = 0; i < 14; i++) begin
      n = vecs[i].k + dmax_of(vecs[i].mode) + 3;
      run_pass(vecs[i].k, vecs[i].mode, n);
      check_int($sformatf("vec%0d probe bit %0d", i, vecs[i].probe),
                int'(h_fin[vecs[i].t][vecs[i].probe]), int'(vecs[i].pval));
      check_int($sformatf("vec%0d popcount", i), $countones(h_fin[vecs[i].t]), vecs[i].pop);
      check_int($sformatf("vec%0d done", i), int'(h_done[vecs[i].t]), int'(vecs[i].edone));
      check_int($sformatf("vec%0d busy", i), int'(h_busy[vecs[i].t]), int'(vecs[i].ebusy));
    end

    // Every PE fires exactly once for a zero-depth pass.
    run_pass(0, 1'b0, 17);
    compare_hist("k0", 0, 1'b0, 17);

    // Reset in the middle of a pass.
    @(negedge clk);
    start = 1'b1; k_len = 8'd5; tile_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check_int("midpass busy before reset", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midpass reset finish", finish, '0);
    check_int("midpass reset busy", int'(busy), 0);
    check_int("midpass reset done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      check_int($sformatf("post-reset quiet c=%0d", c),
                int'(busy) + int'(done) + $countones(finish), 0);
    end

    // Start held high: passes only from IDLE, k_len+dmax+3 apart, never overlapping.
    @(negedge clk);
    start = 1'b1; k_len = 8'd3; tile_mode = 1'b0;
    prev_busy = 0;
    cyc_since = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (busy && prev_busy == 0) begin
        rises.push_back(c);
        cyc_since = 0;
      end else begin
        cyc_since++;
      end
      if (rises.size() > 0 && !(STICKY && cyc_since > 18))
        check($sformatf("spam finish c=%0d", c), finish, model_fin(3, 1'b0, cyc_since));
      prev_busy = int'(busy);
    end
    start = 1'b0;
    check_int("spam pass count", rises.size(), 4);
    for (int i = 1; i < rises.size(); i++)
      check_int($sformatf("spam spacing %0d", i), rises[i] - rises[i-1], 20);
    waited = 0;
    while (busy && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    check_int("spam drain to idle", int'(busy), 0);

    // Randomized passes against the reference model.
    for (int p = 0; p < 12; p++) begin
      k = (p == 11) ? 200 : int'($urandom_range(0, 20));
      mode = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n = k + dmax_of(mode) + 3;
      run_pass(k, mode, n);
      compare_hist($sformatf("rand%0d", p), k, mode, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
